// File: rtl/step_run_ctrl.sv
// Synchronizes one asynchronous board input and filters out contact bounce.
// Latency: 2 synchronizer edges plus DEBOUNCE_CYCLES edges of stable input.
// Backpressure: none; free-running filter whose output is a level.
module step_run_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_100mhz,
    input  logic rst_n,
    input  logic raw,
    output logic db
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchronizer; only sync_q[1] is used downstream.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Count consecutive disagreeing samples; accept the new level once the run is long enough.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db    <= 1'b0;
        end else if (sync_q[1] == db) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            db    <= sync_q[1];
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// CPU clock-enable controller: manual single-step, divided run mode, halt with buzzer.
// Latency: step press to cpu_ce is 3+DEBOUNCE_CYCLES edges; run pulses every RUN_DIV cycles.
// Backpressure: none; halt_req stops pulse generation in the cycle it is sampled.
module step_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RUN_DIV         = 50_000_000,
    parameter int unsigned BUZZ_CYCLES     = 20_000_000
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        halt_req,
    output logic        cpu_ce,
    output logic [15:0] step_cnt,
    output logic        running,
    output logic        Buzzer
);
    localparam int unsigned DIV_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam int unsigned BUZZ_W = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYCLES);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic              step_db, run_db, step_db_q, step_rise;
    logic [DIV_W-1:0]  div_q, div_nxt;
    logic [BUZZ_W-1:0] buzz_q, buzz_nxt;
    logic              buzzer_q, buzzer_nxt;
    logic              ce_q, ce_nxt;
    logic [15:0]       step_cnt_q, step_cnt_nxt;

    step_run_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .raw        (step_btn),
        .db         (step_db)
    );

    step_run_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .raw        (run_sw),
        .db         (run_db)
    );

    // Remember the previous debounced step level so only 0->1 transitions count.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            step_db_q <= 1'b0;
        end else begin
            step_db_q <= step_db;
        end
    end

    assign step_rise = step_db & ~step_db_q;

    // Next-state, divider, buzzer and pulse decisions; halt always has top priority.
    always_comb begin
        state_nxt  = state_q;
        div_nxt    = '0;
        buzz_nxt   = '0;
        buzzer_nxt = 1'b0;
        ce_nxt     = 1'b0;
        case (state_q)
            ST_MANUAL: begin
                if (halt_req) begin
                    state_nxt = ST_HALTED;
                    buzz_nxt  = BUZZ_LOAD;
                end else if (run_db) begin
                    // A step press coinciding with the mode switch is dropped.
                    state_nxt = ST_RUN;
                end else if (step_rise) begin
                    ce_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt = ST_HALTED;
                    buzz_nxt  = BUZZ_LOAD;
                end else if (!run_db) begin
                    state_nxt = ST_MANUAL;
                end else if (div_q == DIV_LAST) begin
                    ce_nxt = 1'b1;
                end else begin
                    div_nxt = div_q + 1'b1;
                end
            end
            ST_HALTED: begin
                if (step_rise) begin
                    // Leaving silences the alarm at once; counter and buzzer stay cleared.
                    state_nxt = ST_MANUAL;
                end else begin
                    buzzer_nxt = (buzz_q != '0);
                    if (buzz_q != '0) begin
                        buzz_nxt = buzz_q - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_MANUAL;
            end
        endcase
        step_cnt_nxt = step_cnt_q + {15'd0, ce_nxt};
    end

    // State, divider, buzzer and pulse registers.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_MANUAL;
            div_q      <= '0;
            buzz_q     <= '0;
            buzzer_q   <= 1'b0;
            ce_q       <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_nxt;
            div_q      <= div_nxt;
            buzz_q     <= buzz_nxt;
            buzzer_q   <= buzzer_nxt;
            ce_q       <= ce_nxt;
            step_cnt_q <= step_cnt_nxt;
        end
    end

    assign cpu_ce   = ce_q;
    assign step_cnt = step_cnt_q;
    assign running  = (state_q == ST_RUN);
    assign Buzzer   = buzzer_q;
endmodule

// File: doc/step_run_ctrl.md
# step_run_ctrl

Clock-enable controller for the single-cycle CPU on the board. It turns the raw step push-button and the run switch into a clean CPU clock-enable: one pulse per press in manual mode, or a divided free-running pulse train in run mode. It also stops the CPU when the core signals halt and sounds the buzzer. It sits between the board I/O and the CPU top, all on the 100 MHz board clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required to accept a button or switch change (10 ms).
- RUN_DIV, 50_000_000: clock cycles per cpu_ce pulse in run mode; must be ≥ 2.
- BUZZ_CYCLES, 20_000_000: buzzer on-time after entering HALTED.

Ports:
- clk_100mhz  in  1  board clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- step_btn  in  1  raw step push-button (asynchronous, bouncing).
- run_sw  in  1  raw run/manual switch (asynchronous); 1 = run.
- halt_req  in  1  synchronous halt indication from the CPU, sampled every cycle.
- cpu_ce  out  1  CPU clock enable; one-cycle pulse per CPU step.
- step_cnt  out  16  count of cpu_ce pulses issued.
- running  out  1  high while in RUN.
- Buzzer  out  1  halt alarm.

## Operation
- Input conditioning: step_btn and run_sw each pass through a 2-flop synchronizer, then a debouncer.
  - Each debouncer counts consecutive cycles in which the synchronized input differs from its debounced output.
  - The count clears to 0 whenever the two are equal.
  - When the count reaches DEBOUNCE_CYCLES-1 and the inputs still differ, the debounced output flips and the count clears.
- step_rise: one-cycle registered pulse on a 0→1 transition of the debounced step signal. Falling edges are ignored.
- State machine (registered state; reset state is MANUAL):
  - MANUAL: step_rise → cpu_ce=1 for one cycle, step_cnt+1.
    - halt_req=1 → HALTED. It takes priority over step_rise in the same cycle, so no pulse is issued.
    - Debounced run=1 (and halt_req=0) → RUN, with the divider cleared to 0. A step_rise in the same cycle is dropped.
  - RUN: divider counts 0..RUN_DIV-1 and wraps. In the cycle the divider equals RUN_DIV-1: cpu_ce=1 and step_cnt+1.
    - halt_req=1 → HALTED, with no pulse that cycle even if the divider is at terminal count.
    - Debounced run=0 → MANUAL, divider cleared, no pulse that cycle. halt_req wins if both are true.
    - step_rise is ignored.
  - HALTED: cpu_ce=0.
    - On entry the buzzer counter loads BUZZ_CYCLES. Buzzer=1 while the counter is nonzero, and the counter decrements each cycle.
    - step_rise → MANUAL with no pulse. The buzzer counter is cleared immediately.
    - If halt_req is still 1 in MANUAL, the block returns to HALTED on the next cycle and the buzzer counter reloads.
- step_cnt: 16-bit, wraps 0xFFFF→0x0000, and increments only together with cpu_ce.
- running = (state == RUN).
- Reset mid-operation: all state clears at once. Any pending debounce progress is lost. A button still held after reset release is treated as already-pressed only once the debouncer accepts it, which yields one step_rise.

## Timing
- Reset values:
  - cpu_ce=0, step_cnt=0, running=0, Buzzer=0.
  - State MANUAL; debounced step=0 and run=0; divider=0; buzzer counter=0; synchronizers=0.
- Step latency: for a raw step_btn rising and held stable, cpu_ce pulses exactly 3+DEBOUNCE_CYCLES clock edges after the first edge that samples it high. This is 2 sync edges, DEBOUNCE_CYCLES debounce edges, and 1 edge-detect/output edge.
- Run mode: the first cpu_ce comes RUN_DIV cycles after running rises. After that the period is exactly RUN_DIV cycles with a 1-cycle high time.
- Mode switch latency: running changes 1 cycle after the debounced run value changes.
- Buzzer: rises 1 cycle after entering HALTED and stays high for exactly BUZZ_CYCLES cycles.
- cpu_ce is registered and never high for two consecutive cycles.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, RUN_DIV=5, BUZZ_CYCLES=3.
- Reset/idle: hold rst_n=0, toggle inputs → all outputs 0. Release with inputs at 0 → no cpu_ce for 50 cycles.
- Bounce rejection: toggle step_btn every 2 cycles for 20 cycles, then hold at 1 → exactly one cpu_ce, 7 edges after the hold starts; step_cnt=1. Release and press again → step_cnt=2.
- Run mode: set run_sw=1 and hold → running rises after 7 edges. cpu_ce then pulses every 5 cycles; after 10 pulses step_cnt=10. Clear run_sw → running falls, and no pulse appears once MANUAL is entered.
- Halt: in RUN, pulse halt_req on a divider terminal-count cycle → no cpu_ce that cycle, running=0, Buzzer high for exactly 3 cycles. Presses while halt_req=0 and state HALTED → first press returns to MANUAL with no pulse, the second press gives one pulse.
- Wrap: preload by running 65535 pulses, then one more → step_cnt goes from 0xFFFF to 0x0000.
- Async reset mid-run: assert rst_n low between cycles while in RUN → outputs clear immediately, without waiting for a clock edge. With run_sw still 1, running rises again 7 edges after release.
